add16_sched: RTL and testbench

ADD16_SCHED -- requirements
Module: add16_sched

---
 rtl/add16_sched_pkg.sv | 14 +
 rtl/add16_sched_rr_arbiter.sv | 30 +++
 rtl/add16_sched.sv | 125 ++++++++++++
 tb/tb_add16_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/add16_sched_pkg.sv
// Shared types and default sizing for the add16_sched adder scheduler.
package add16_sched_pkg;

   localparam int DEF_WIDTH      = 16;
   localparam int DEF_SETTLE_CYC = 3;
   localparam int CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/add16_sched_rr_arbiter.sv
// Round-robin one-hot arbiter: the lowest valid request at or above ptr wins,
// otherwise the search wraps to the lowest valid request overall.
module rr_arbiter #(
   parameter int N_REQ = 4,
   localparam int ID_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt
);

   logic [N_REQ-1:0] mask_hi;
   logic [N_REQ-1:0] req_hi;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
      assign mask_hi[gi] = (ID_W'(gi) >= ptr);
   end

   assign req_hi = req & mask_hi;

   // x & -x isolates the lowest set bit.
   always_comb begin
      if (|req_hi) begin
         gnt = req_hi & (~req_hi + 1'b1);
      end else begin
         gnt = req & (~req + 1'b1);
      end
   end

endmodule

// File: rtl/add16_sched.sv
// Time-shares one external adder between N_REQ requesters: round-robin grant,
// operands held for SETTLE_CYC cycles, then the sum is registered and returned.
module add16_sched
   import add16_sched_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int WIDTH      = DEF_WIDTH,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*WIDTH-1:0]     req_a,
   input  logic [N_REQ*WIDTH-1:0]     req_b,
   output logic [WIDTH-1:0]           add_a,
   output logic [WIDTH-1:0]           add_b,
   input  logic [WIDTH-1:0]           add_o,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [WIDTH-1:0]           rsp_sum,
   output logic [$clog2(N_REQ)-1:0]   rsp_id
);

   localparam int ID_W = $clog2(N_REQ);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [ID_W-1:0]   ptr_reg, ptr_next;
   logic [WIDTH-1:0]  add_a_reg, add_a_next;
   logic [WIDTH-1:0]  add_b_reg, add_b_next;
   logic [WIDTH-1:0]  rsp_sum_reg, rsp_sum_next;
   logic [ID_W-1:0]   rsp_id_reg, rsp_id_next;

   logic [N_REQ-1:0]  gnt;
   logic [ID_W-1:0]   grant_id;
   logic [WIDTH-1:0]  a_arr [N_REQ];
   logic [WIDTH-1:0]  b_arr [N_REQ];

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
   end

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_reg),
      .gnt (gnt)
   );

   always_comb begin
      grant_id = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt[i]) grant_id = ID_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         ptr_reg     <= '0;
         add_a_reg   <= '0;
         add_b_reg   <= '0;
         rsp_sum_reg <= '0;
         rsp_id_reg  <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         ptr_reg     <= ptr_next;
         add_a_reg   <= add_a_next;
         add_b_reg   <= add_b_next;
         rsp_sum_reg <= rsp_sum_next;
         rsp_id_reg  <= rsp_id_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      ptr_next     = ptr_reg;
      add_a_next   = add_a_reg;
      add_b_next   = add_b_reg;
      rsp_sum_next = rsp_sum_reg;
      rsp_id_next  = rsp_id_reg;
      req_ready    = '0;
      rsp_valid    = 1'b0;

      case (state_reg)
         IDLE: begin
            req_ready = gnt;
            if (|(gnt & req_valid)) begin
               add_a_next  = a_arr[grant_id];
               add_b_next  = b_arr[grant_id];
               rsp_id_next = grant_id;
               cnt_next    = CNT_W'(SETTLE_CYC - 1);
               ptr_next    = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
               state_next  = SETTLE;
            end
         end
         SETTLE: begin
            // Sample the adder on the last settle cycle, once operands have been stable.
            if (cnt_reg == '0) begin
               rsp_sum_next = add_o;
               state_next   = RESP;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign add_a   = add_a_reg;
   assign add_b   = add_b_reg;
   assign rsp_sum = rsp_sum_reg;
   assign rsp_id  = rsp_id_reg;

endmodule

// File: tb/tb_add16_sched.sv
// Randomized and directed checks of add16_sched against a transaction-level
// model; the shared adder is emulated with a selectable 0..2 cycle output delay.
module tb_add16_sched;

   localparam int N = 4;
   localparam int W = 16;
   localparam int S = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic [W-1:0]   add_o;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [W-1:0]   rsp_sum;
   logic [1:0]     rsp_id;

   always #5 clk = ~clk;

   add16_sched #(
      .N_REQ      (N),
      .WIDTH      (W),
      .SETTLE_CYC (S)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_o     (add_o),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_id    (rsp_id)
   );

   // Shared adder with optional output latency
   logic [W-1:0] d1, d2;
   int           dly;
   always @(posedge clk) begin
      d1 <= add_a + add_b;
      d2 <= d1;
   end
   assign add_o = (dly == 0) ? W'(add_a + add_b) : (dly == 1) ? d1 : d2;

   int errors = 0;
   int checks = 0;

   // Transaction model state
   bit           busy = 1'b0;
   int           last_id = N - 1;
   int           acc_edge = 0;
   int           seen_edge = -1;
   int           edge_cnt = 0;
   logic [W-1:0] m_a, m_b;
   int           m_id;
   int           ops = 0;
   logic [W-1:0] last_sum;
   int           last_rid;
   int           last_lat;
   int           grant_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (last + k) % N;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
   endtask

   task automatic chk_zero();
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_add_a", add_a, 0);
      chk("rst_add_b", add_b, 0);
   endtask

   // One clock: check at negedge against the model, then advance the model to the next edge.
   task automatic step();
      int           exp_w;
      logic [N-1:0] exp_ready;
      bit           rsp_exp;
      logic [W-1:0] exp_sum;
      @(negedge clk);
      exp_ready = '0;
      exp_w = -1;
      if (!busy) begin
         exp_w = rr_pick(req_valid, last_id);
         if (exp_w >= 0) exp_ready[exp_w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      for (int i = 0; i < N; i++) begin
         if (req_ready[i]) grant_q.push_back(i);
      end
      rsp_exp = busy && (edge_cnt >= acc_edge + S);
      chk("rsp_valid", rsp_valid, rsp_exp);
      if (rsp_valid && seen_edge < 0) seen_edge = edge_cnt;
      if (rsp_exp) begin
         exp_sum = m_a + m_b;
         chk("rsp_sum", rsp_sum, exp_sum);
         chk("rsp_id", rsp_id, m_id);
      end
      if (busy) begin
         chk("add_a_hold", add_a, m_a);
         chk("add_b_hold", add_b, m_b);
      end
      if (rst) begin
         busy = 1'b0;
         last_id = N - 1;
      end else if (exp_w >= 0) begin
         busy = 1'b1;
         acc_edge = edge_cnt + 1;
         seen_edge = -1;
         m_a = req_a[exp_w*W +: W];
         m_b = req_b[exp_w*W +: W];
         m_id = exp_w;
         last_id = exp_w;
      end else if (rsp_exp && rsp_ready) begin
         busy = 1'b0;
         ops++;
         last_sum = rsp_sum;
         last_rid = rsp_id;
         last_lat = seen_edge - acc_edge;
      end
      @(posedge clk);
      edge_cnt++;
      #1;
   endtask

   task automatic run_until_ops(input int target, input int budget);
      int n;
      n = 0;
      while (ops < target && n < budget) begin
         step();
         n++;
      end
      if (ops < target) chk("timeout_ops", ops, target);
   endtask

   initial begin
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      int start_ops;
      int budget;

      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      dly = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero();
      rst = 1'b0;

      // Single request from requester 2
      set_op(2, 16'h1234, 16'h0FF0);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      run_until_ops(ops + 1, 50);
      chk("single_sum", last_sum, 16'h2224);
      chk("single_id", last_rid, 2);
      chk("single_lat", last_lat, S);
      $display("single: sum=%0h id=%0d lat=%0d", last_sum, last_rid, last_lat);

      // Modulo wraparound
      set_op(1, 16'hFFFF, 16'h0001);
      req_valid = 4'b0010;
      step();
      req_valid = '0;
      run_until_ops(ops + 1, 50);
      chk("wrap_ffff", last_sum, 16'h0000);
      $display("wrap: FFFF+0001 -> %0h", last_sum);
      set_op(3, 16'h8000, 16'h8000);
      req_valid = 4'b1000;
      step();
      req_valid = '0;
      run_until_ops(ops + 1, 50);
      chk("wrap_8000", last_sum, 16'h0000);
      $display("wrap: 8000+8000 -> %0h", last_sum);

      // Reset during SETTLE abandons the operation
      set_op(0, 16'h1111, 16'h2222);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_zero();
      start_ops = ops;
      repeat (8) step();
      chk("rst_no_rsp", ops, start_ops);
      $display("reset-in-settle: outputs cleared, no response");

      // Contention: round-robin order from index 0
      for (int i = 0; i < N; i++) set_op(i, 16'(16'h0100 * (i + 1)), 16'(i + 7));
      grant_q.delete();
      req_valid = '1;
      run_until_ops(ops + 5, 100);
      chk("cont_count", grant_q.size(), 5);
      for (int k = 0; k < 5; k++) begin
         chk("cont_order", (k < grant_q.size()) ? grant_q[k] : -1, exp_ord[k]);
      end
      $display("contention: %0d grants observed", grant_q.size());

      // Backpressure: result held while consumer stalls
      rsp_ready = 1'b0;
      repeat (S + 1 + 6) step();
      chk("bp_no_handshake", rsp_valid, 1);
      rsp_ready = 1'b1;
      run_until_ops(ops + 1, 20);
      req_valid = '0;
      $display("backpressure: released, sum=%0h id=%0d", last_sum, last_rid);

      // Random operations with a delayed adder
      start_ops = ops;
      budget = 0;
      while (ops < start_ops + 1000 && budget < 20000) begin
         req_valid = N'($urandom_range(0, (1 << N) - 1));
         for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom));
         rsp_ready = ($urandom_range(0, 3) != 0);
         dly = $urandom_range(0, 2);
         step();
         budget++;
      end
      chk("rand_ops", ops - start_ops, 1000);
      $display("random: %0d operations in %0d cycles", ops - start_ops, budget);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
